// File: rtl/mips_exc_pkg.sv
// Shared exception-commit types: ExcCode values, stage record and sequencer states.
package mips_exc_pkg;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        bd;
        logic        adel_if;
        logic        ri;
        logic        sys;
        logic        bp;
        logic        eret;
        logic        ov;
    } exc_rec_t;

    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StRedirect
    } exc_state_e;

endpackage

// File: rtl/exc_prio_enc.sv
// Commit-point priority encoder: picks one exception for the MEM record.
module exc_prio_enc
    import mips_exc_pkg::*;
(
    input  exc_rec_t    rec,
    input  logic        int_pending,
    input  logic [31:0] mem_addr,
    input  logic        mem_ld_h,
    input  logic        mem_ld_w,
    input  logic        mem_st_h,
    input  logic        mem_st_w,
    output logic        hit,
    output logic [4:0]  code,
    output logic        badv_we,
    output logic [31:0] badvaddr
);

    logic ld_fault;
    logic st_fault;

    assign ld_fault = (mem_ld_h & mem_addr[0]) | (mem_ld_w & (|mem_addr[1:0]));
    assign st_fault = (mem_st_h & mem_addr[0]) | (mem_st_w & (|mem_addr[1:0]));

    always_comb begin
        hit      = 1'b1;
        code     = EXC_INT;
        badv_we  = 1'b0;
        badvaddr = '0;
        if (!rec.valid) begin
            hit = 1'b0;
        end else if (int_pending) begin
            code = EXC_INT;
        end else if (rec.adel_if) begin
            code     = EXC_ADEL;
            badv_we  = 1'b1;
            badvaddr = rec.pc;
        end else if (rec.ri) begin
            code = EXC_RI;
        end else if (rec.sys) begin
            code = EXC_SYS;
        end else if (rec.bp) begin
            code = EXC_BP;
        end else if (rec.ov) begin
            code = EXC_OV;
        end else if (ld_fault) begin
            code     = EXC_ADEL;
            badv_we  = 1'b1;
            badvaddr = mem_addr;
        end else if (st_fault) begin
            code     = EXC_ADES;
            badv_we  = 1'b1;
            badvaddr = mem_addr;
        end else begin
            hit = 1'b0;
        end
    end

endmodule

// File: rtl/exc_commit_ctrl.sv
// Carries exception flags ID->EX->MEM, commits one exception/ERET at MEM, then
// flushes, drains outstanding AXI traffic and redirects fetch.
module exc_commit_ctrl
    import mips_exc_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter int unsigned DRAIN_MAX  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        adv,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic        id_bd,
    input  logic        id_adel_if,
    input  logic        id_ri,
    input  logic        id_sys,
    input  logic        id_bp,
    input  logic        id_eret,
    input  logic        ex_ov,
    input  logic [31:0] mem_addr,
    input  logic        mem_ld_h,
    input  logic        mem_ld_w,
    input  logic        mem_st_h,
    input  logic        mem_st_w,
    input  logic        int_pending,
    input  logic [31:0] cp0_epc,
    input  logic        axi_busy,
    output logic        exc_req,
    output logic [4:0]  exc_code,
    output logic [31:0] exc_epc,
    output logic        exc_bd,
    output logic        exc_badv_we,
    output logic [31:0] exc_badvaddr,
    output logic        eret_req,
    output logic        flush,
    output logic        stall_all,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        drain_timeout
);

    localparam int unsigned CW = $clog2(DRAIN_MAX + 1);

    exc_state_e  state_q, state_d;
    exc_rec_t    ex_q, mem_q, id_rec, ex_next;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [31:0] target_q, target_d;
    logic        timeout_q, timeout_d;
    logic        hit, badv_we, kill;
    logic [4:0]  code;
    logic [31:0] badvaddr;

    always_comb begin
        id_rec         = '0;
        id_rec.valid   = id_valid;
        id_rec.pc      = id_pc;
        id_rec.bd      = id_bd;
        id_rec.adel_if = id_adel_if;
        id_rec.ri      = id_ri;
        id_rec.sys     = id_sys;
        id_rec.bp      = id_bp;
        id_rec.eret    = id_eret;
        ex_next        = ex_q;
        ex_next.ov     = ex_q.ov | ex_ov;
    end

    // Anything entering the pipe during the commit cycle or the drain is wrong-path.
    assign kill = flush | (state_q == StDrain);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
        end else if (kill) begin
            ex_q  <= '0;
            mem_q <= '0;
        end else if (adv) begin
            ex_q  <= id_rec;
            mem_q <= ex_next;
        end
    end

    exc_prio_enc u_prio (
        .rec         (mem_q),
        .int_pending (int_pending),
        .mem_addr    (mem_addr),
        .mem_ld_h    (mem_ld_h),
        .mem_ld_w    (mem_ld_w),
        .mem_st_h    (mem_st_h),
        .mem_st_w    (mem_st_w),
        .hit         (hit),
        .code        (code),
        .badv_we     (badv_we),
        .badvaddr    (badvaddr)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        target_d       = target_q;
        timeout_d      = timeout_q;
        exc_req        = 1'b0;
        eret_req       = 1'b0;
        flush          = 1'b0;
        stall_all      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        cnt_inc        = cnt_q + CW'(1);
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (hit) begin
                    exc_req   = 1'b1;
                    flush     = 1'b1;
                    stall_all = 1'b1;
                    target_d  = EXC_VECTOR;
                    state_d   = StDrain;
                end else if (mem_q.valid && mem_q.eret) begin
                    eret_req  = 1'b1;
                    flush     = 1'b1;
                    stall_all = 1'b1;
                    target_d  = cp0_epc;
                    state_d   = StDrain;
                end
            end
            StDrain: begin
                stall_all = 1'b1;
                if (!axi_busy) begin
                    state_d = StRedirect;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CW'(DRAIN_MAX)) begin
                        timeout_d = 1'b1;
                        state_d   = StRedirect;
                    end
                end
            end
            StRedirect: begin
                redirect_valid = 1'b1;
                redirect_pc    = target_q;
                state_d        = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            target_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            target_q  <= target_d;
            timeout_q <= timeout_d;
        end
    end

    assign exc_code      = exc_req ? code : '0;
    assign exc_epc       = exc_req ? (mem_q.bd ? mem_q.pc - 32'd4 : mem_q.pc) : '0;
    assign exc_bd        = exc_req & mem_q.bd;
    assign exc_badv_we   = exc_req & badv_we;
    assign exc_badvaddr  = exc_req ? badvaddr : '0;
    assign drain_timeout = timeout_q;

endmodule
